nios2_vga_clock_nco_gen: RTL and testbench
==========================================

Name: nios2_vga_clock_nco_gen

Overview:
- Parametrised multi-channel clock generator for the VGA/LCD clock domain.
- Produces NUM_CLOCKS 50%-nominal output clocks and per-channel tick strobes from one reference clock, using phase-accumulator NCOs.
- Per-channel increments are reprogrammable at runtime from the Nios II side. Updates are glitch-free: a new increment takes effect only at the channel's accumulator wrap.
- Provides a `locked` indication that drops on reprogramming and reasserts after a fixed settling interval.

Parameters:
- NUM_CLOCKS, 3, number of output channels (1..8).
- ACC_WIDTH, 32, accumulator and increment width in bits.
- LOCK_CYCLES, 16, refclk cycles from reset release or config application to `locked`=1 (>=1).
- INIT_INC, {32'hA8F5C28F, 32'h80000000, 32'h80000000}, packed reset increments. Channel i occupies bits [i*ACC_WIDTH +: ACC_WIDTH]. Defaults give 33/25/25 MHz from 50 MHz.

Ports:
- refclk  in  1  reference clock; all logic is synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- chan_en  in  NUM_CLOCKS  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; the transfer occurs when cfg_valid & cfg_ready.
- cfg_chan  in  3  target channel index.
- cfg_inc  in  ACC_WIDTH  new increment.
- cfg_err  out  1  one-cycle pulse: request addressed a channel >= NUM_CLOCKS.
- outclk  out  NUM_CLOCKS  generated clocks. outclk[i] = MSB of acc[i] (registered).
- tick  out  NUM_CLOCKS  one-cycle strobe, registered carry of the add that produced the current acc[i].
- locked  out  1  all channels running on settled increments.

Behaviour:
- Reset (async assert, sync release):
  - acc = 0; inc = INIT_INC.
  - outclk = 0, tick = 0, cfg_err = 0, locked = 0, cfg_ready = 1.
  - Pending register cleared; lock counter = 0; FSM = SETTLE.
- Channel update each refclk edge with chan_en[i]=1:
  - {carry, acc[i]} <= acc[i] + inc[i], modulo 2^ACC_WIDTH.
  - tick[i] <= carry.
- Channel with chan_en[i]=0: acc[i] <= 0 and tick[i] <= 0 synchronously, so outclk[i]=0 from the next cycle. chan_en does not affect locked.
- inc[i]=0: acc frozen, outclk static, no ticks.
- Output frequency = f_refclk * inc / 2^ACC_WIDTH. Valid when inc <= 2^(ACC_WIDTH-1). Larger values alias; no check is made.
- Config handshake:
  - On acceptance, cfg_chan/cfg_inc are captured into the pending register and cfg_ready drops next cycle.
  - cfg_chan >= NUM_CLOCKS: request dropped, cfg_err pulses next cycle, cfg_ready returns 1 the cycle after, locked unaffected.
  - Valid channel c: the pending value is written to inc[c] on the first cycle where the channel's add produces carry=1. That add still uses the old inc; the new inc is used from the following add.
  - If chan_en[c]=0 or inc[c]=0, the value is applied on the next cycle instead (no wrap wait).
  - cfg_ready = 1 the cycle after application. Only one request is outstanding at a time.
- Lock FSM, states SETTLE and LOCKED:
  - SETTLE: counter increments each cycle while no valid request is pending. At counter = LOCK_CYCLES-1 go to LOCKED (locked=1 next cycle).
  - LOCKED: on acceptance of a valid-channel request, locked=0 next cycle and go to SETTLE with counter=0. The counter holds at 0 until the request is applied.
  - A new valid request accepted during SETTLE restarts the count after its application.
- Simultaneous events:
  - Acceptance and a carry on the target channel in the same cycle: that carry does not apply the new value; the next carry does.
  - Reset assertion mid-request discards the pending value; inc returns to INIT_INC.
- Latency summary:
  - acc/outclk/tick: 1 cycle after the edge.
  - Config: accept -> apply = wait for wrap, or 1 cycle for a disabled/zero-increment channel.
  - locked: LOCK_CYCLES after reset release or after config application.

Test Plan:
- Reset release, defaults, chan_en=3'b111 -> outclk[0] and outclk[1] = 1,0,1,0... from cycle 1; tick[0] high on even cycles; locked=1 after exactly 16 cycles.
- Channel 2 at 0xA8F5C28F over 1000 cycles -> 660 ticks (±1); outclk[2] high 495–505 cycles.
- Write ch1 inc=0x40000000 -> applied at the next wrap; outclk[1] period becomes 4 cycles (0,1,1,0 pattern shifted); locked low from the accept+1 cycle until 16 cycles after application; no high or low phase shorter than the old/new nominal half-period.
- Write cfg_chan=5 -> cfg_err pulses once, cfg_ready drops for exactly 1 cycle, locked stays 1, all inc values unchanged.
- chan_en[2]=0, then write ch2 inc=0x20000000 -> applied 1 cycle after accept; outclk[2]=0 while disabled; after re-enable the period is 8 cycles.
- Assert rst_n=0 while a ch0 request is pending -> all outputs go to reset values immediately; after release ch0 runs at 0x80000000 and cfg_ready=1.

Source files
------------

// File: rtl/nios2_vga_clock_nco_gen_if.sv
// Nios II side configuration port for the VGA clock NCO bank.
// Master issues increment writes; slave accepts and flags bad channels.
interface nios2_vga_clock_nco_gen_if #(
  parameter int ACC_WIDTH = 32
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [2:0]           cfg_chan;
  logic [ACC_WIDTH-1:0] cfg_inc;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_inc,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_inc,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/nios2_vga_clock_nco_gen.sv
// Multi-channel phase-accumulator clock generator for the VGA domain.
// Increments reload only on accumulator wrap so outputs never glitch.
module nios2_vga_clock_nco_gen #(
  parameter int NUM_CLOCKS  = 3,
  parameter int ACC_WIDTH   = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INIT_INC =
    {32'hA8F5C28F, 32'h80000000, 32'h80000000}
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic [NUM_CLOCKS-1:0] chan_en,
  nios2_vga_clock_nco_gen_if.slave cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {
    S_SETTLE,
    S_LOCKED
  } lock_e;

  logic [ACC_WIDTH-1:0] acc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0] acc_d [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0] inc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0] inc_d [NUM_CLOCKS];
  logic [ACC_WIDTH:0]   sum   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] tick_q, tick_d;

  logic                 busy_q, busy_d;
  logic                 perr_q, perr_d;
  logic [2:0]           pchan_q, pchan_d;
  logic [ACC_WIDTH-1:0] pinc_q, pinc_d;

  lock_e                state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic accept;
  logic chan_ok;
  logic pend_ok;

  assign accept  = cfg.cfg_valid & ~busy_q;
  assign chan_ok = {1'b0, cfg.cfg_chan} < 4'(NUM_CLOCKS);
  assign pend_ok = busy_q & ~perr_q;

  assign cfg.cfg_ready = ~busy_q;
  assign cfg.cfg_err   = perr_q;
  assign tick          = tick_q;
  assign locked        = (state_q == S_LOCKED);

  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      outclk[i] = acc_q[i][ACC_WIDTH-1];
    end
  end

  always_comb begin
    busy_d  = busy_q;
    perr_d  = perr_q;
    pchan_d = pchan_q;
    pinc_d  = pinc_q;
    tick_d  = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      acc_d[i]  = chan_en[i] ? sum[i][ACC_WIDTH-1:0] : '0;
      tick_d[i] = chan_en[i] & sum[i][ACC_WIDTH];
      inc_d[i]  = inc_q[i];
      // Stopped or frozen channels have no wrap to wait for.
      if (pend_ok && pchan_q == 3'(i) &&
          (!chan_en[i] || inc_q[i] == '0 || sum[i][ACC_WIDTH])) begin
        inc_d[i] = pinc_q;
        busy_d   = 1'b0;
      end
    end
    if (busy_q && perr_q) begin
      busy_d = 1'b0;
      perr_d = 1'b0;
    end
    if (accept) begin
      busy_d  = 1'b1;
      perr_d  = ~chan_ok;
      pchan_d = cfg.cfg_chan;
      pinc_d  = cfg.cfg_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_SETTLE: begin
        if (pend_ok || (accept && chan_ok)) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (accept && chan_ok) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INIT_INC[i*ACC_WIDTH +: ACC_WIDTH];
      end
      tick_q  <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
      pchan_q <= '0;
      pinc_q  <= '0;
      state_q <= S_SETTLE;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      pchan_q <= pchan_d;
      pinc_q  <= pinc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_nios2_vga_clock_nco_gen.sv
// Directed bench for the VGA clock NCO bank.
// Edge numbers count refclk rises since the last reset release.
module tb_nios2_vga_clock_nco_gen;
  logic       refclk = 1'b0;
  logic       rst_n;
  logic [2:0] chan_en;
  logic [2:0] outclk;
  logic [2:0] tick;
  logic       locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ticks2;
  int high2;

  nios2_vga_clock_nco_gen_if #(.ACC_WIDTH(32)) cfg_if ();

  nios2_vga_clock_nco_gen dut (
    .refclk  (refclk),
    .rst_n   (rst_n),
    .chan_en (chan_en),
    .cfg     (cfg_if.slave),
    .outclk  (outclk),
    .tick    (tick),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h, want %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    cyc++;
    @(negedge refclk);
  endtask

  initial begin
    rst_n            = 1'b0;
    chan_en          = 3'b111;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = 3'd0;
    cfg_if.cfg_inc   = '0;
    @(negedge refclk);
    @(negedge refclk);
    chk("rst_outclk", 64'(outclk), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
    chk("rst_err", 64'(cfg_if.cfg_err), 64'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // Defaults: ch0/ch1 toggle every edge, lock after 16 edges
    for (int k = 0; k < 20; k++) begin
      step();
      chk("def_clk0", 64'(outclk[0]), 64'(cyc % 2 == 1));
      chk("def_clk1", 64'(outclk[1]), 64'(cyc % 2 == 1));
      chk("def_tick0", 64'(tick[0]), 64'(cyc % 2 == 0));
      chk("def_lock", 64'(locked), 64'(cyc >= 16));
    end

    // Channel 2 at 0.66 of refclk
    ticks2 = 0;
    high2  = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (tick[2]) ticks2++;
      if (outclk[2]) high2++;
    end
    chk("ch2_ticks", 64'(ticks2 >= 659 && ticks2 <= 661), 64'd1);
    chk("ch2_duty", 64'(high2 >= 495 && high2 <= 505), 64'd1);

    // Reprogram ch1 to quarter rate: accept at 1021, apply at 1022
    cfg_if.cfg_chan  = 3'd1;
    cfg_if.cfg_inc   = 32'h40000000;
    cfg_if.cfg_valid = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      cfg_if.cfg_valid = 1'b0;
      if (cyc <= 1022) begin
        chk("wr1_clk1", 64'(outclk[1]), 64'(cyc % 2 == 1));
        chk("wr1_tick1", 64'(tick[1]), 64'(cyc % 2 == 0));
      end else begin
        chk("wr1_clk1", 64'(outclk[1]), 64'((cyc - 1022) % 4 >= 2));
        chk("wr1_tick1", 64'(tick[1]), 64'((cyc - 1022) % 4 == 0));
      end
      chk("wr1_ready", 64'(cfg_if.cfg_ready), 64'(cyc != 1021));
      chk("wr1_lock", 64'(locked), 64'(cyc >= 1038));
    end

    // Bad channel: accept at 1039, err pulse, lock untouched
    cfg_if.cfg_chan  = 3'd5;
    cfg_if.cfg_inc   = 32'h12345678;
    cfg_if.cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      cfg_if.cfg_valid = 1'b0;
      chk("bad_err", 64'(cfg_if.cfg_err), 64'(cyc == 1039));
      chk("bad_ready", 64'(cfg_if.cfg_ready), 64'(cyc != 1039));
      chk("bad_lock", 64'(locked), 64'd1);
      chk("bad_clk0", 64'(outclk[0]), 64'(cyc % 2 == 1));
      chk("bad_clk1", 64'(outclk[1]), 64'((cyc - 1022) % 4 >= 2));
    end

    // Disabled ch2: write applies one edge after accept
    chan_en = 3'b011;
    step();
    chk("dis_clk2", 64'(outclk[2]), 64'd0);
    chk("dis_tick2", 64'(tick[2]), 64'd0);
    cfg_if.cfg_chan  = 3'd2;
    cfg_if.cfg_inc   = 32'h20000000;
    cfg_if.cfg_valid = 1'b1;
    for (int k = 0; k < 21; k++) begin
      step();
      cfg_if.cfg_valid = 1'b0;
      if (cyc <= 1047) begin
        chk("dis_clk2", 64'(outclk[2]), 64'd0);
        chk("dis_tick2", 64'(tick[2]), 64'd0);
      end else begin
        chk("en_clk2", 64'(outclk[2]), 64'((cyc - 1047) % 8 >= 4));
        chk("en_tick2", 64'(tick[2]), 64'((cyc - 1047) % 8 == 0));
      end
      chk("dis_ready", 64'(cfg_if.cfg_ready), 64'(cyc != 1043));
      chk("dis_lock", 64'(locked), 64'(cyc >= 1060));
      if (cyc == 1047) chan_en = 3'b111;
    end

    // Reset while a ch0 request is pending
    cfg_if.cfg_chan  = 3'd0;
    cfg_if.cfg_inc   = 32'h40000000;
    cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("mid_ready", 64'(cfg_if.cfg_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_outclk", 64'(outclk), 64'd0);
    chk("mid_tick", 64'(tick), 64'd0);
    chk("mid_locked", 64'(locked), 64'd0);
    chk("mid_ready_rst", 64'(cfg_if.cfg_ready), 64'd1);
    chk("mid_err", 64'(cfg_if.cfg_err), 64'd0);
    @(negedge refclk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_clk0", 64'(outclk[0]), 64'(cyc % 2 == 1));
      chk("post_tick0", 64'(tick[0]), 64'(cyc % 2 == 0));
      chk("post_ready", 64'(cfg_if.cfg_ready), 64'd1);
      chk("post_lock", 64'(locked), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
